// File: rtl/ram_bist_seq.sv
// ram_bist_seq
//
// Test sequencer for the 16x8 excess-3 RAM stage. When `start` is accepted,
// it writes the digit pattern (i mod 10) to addresses 0..N_WORDS-1 through
// the RAM stage's BCD-to-excess-3 encoder. It then reads the same addresses
// back, decodes each excess-3 word to BCD, and counts the mismatches.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; forces IDLE, drops CS
//   start      in   begin a run (sampled only in IDLE)
//   a          out  BCD digit to the RAM stage encoder
//   addr       out  RAM address
//   CS         out  RAM chip select
//   WE         out  RAM write enable (1 = write, 0 = read)
//   ram_data   in   RAM stage dataOut (registered inside the RAM stage)
//   busy       out  run in progress
//   done       out  one-cycle pulse at the end of a run
//   bcd_out    out  decoded readback digit (4'hF for an illegal code)
//   bcd_valid  out  bcd_out/err valid this cycle
//   err        out  current readback mismatches, qualified by bcd_valid
//   err_cnt    out  mismatch count of current/last run, saturates at 31
//   dbg_state  out  current FSM state (state_t encoding)
//
// Handshake: there is no back-pressure. The RAM stage returns read data one
// cycle after the read is driven, and this block registers the decoded result
// one cycle later. A read driven after edge k therefore produces bcd_valid
// after edge k+2.

module ram_bist_seq #(
  parameter int N_WORDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] addr,
  output logic       CS,
  output logic       WE,
  input  logic [7:0] ram_data,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_out,
  output logic       bcd_valid,
  output logic       err,
  output logic [4:0] err_cnt,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_ADDR = 4'(N_WORDS - 1);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  state_t     state, state_nx;
  logic [3:0] a_nx, addr_nx;
  logic       cs_nx, we_nx, busy_nx, done_nx;
  logic       clr_cnt;

  // Read pipeline stage 1: a read was driven on the previous cycle. The RAM
  // stage presents its data during this cycle, alongside the digit that the
  // read is expected to return.
  logic       rd_v1;
  logic [3:0] rd_exp1;

  // Readback decode of the word currently on ram_data.
  logic       code_ok;
  logic [3:0] dec_digit;
  logic       mism;

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // FSM: next state and next registered RAM-side outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    a_nx     = a;
    addr_nx  = addr;
    cs_nx    = CS;
    we_nx    = WE;
    busy_nx  = busy;
    done_nx  = 1'b0;
    clr_cnt  = 1'b0;

    unique case (state)
      S_IDLE: begin
        cs_nx   = 1'b0;
        busy_nx = 1'b0;
        if (start) begin
          state_nx = S_WRITE;
          a_nx     = 4'd0;
          addr_nx  = 4'd0;
          cs_nx    = 1'b1;
          we_nx    = 1'b1;
          busy_nx  = 1'b1;
          clr_cnt  = 1'b1;
        end
      end

      S_WRITE: begin
        if (addr == LAST_ADDR) begin
          // The next cycle is the first read, at address 0.
          state_nx = S_READ;
          a_nx     = 4'd0;
          addr_nx  = 4'd0;
          we_nx    = 1'b0;
        end else begin
          addr_nx = addr + 4'd1;
          a_nx    = (a == 4'd9) ? 4'd0 : a + 4'd1;
        end
      end

      S_READ: begin
        if (addr == LAST_ADDR) begin
          state_nx = S_DRAIN;
          addr_nx  = 4'd0;
          cs_nx    = 1'b0;
          we_nx    = 1'b0;
        end else begin
          addr_nx = addr + 4'd1;
        end
      end

      // One empty cycle lets the final read drain through the RAM register.
      S_DRAIN: begin
        state_nx = S_DONE;
        cs_nx    = 1'b0;
        done_nx  = 1'b1;
      end

      S_DONE: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end

      default: begin
        state_nx = S_IDLE;
        cs_nx    = 1'b0;
        we_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a     <= 4'd0;
      addr  <= 4'd0;
      CS    <= 1'b0;
      WE    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      a     <= a_nx;
      addr  <= addr_nx;
      CS    <= cs_nx;
      WE    <= we_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  // ---------------------------------------------------------------------
  // Readback decode: a legal excess-3 word is 8'h03..8'h0C
  // ---------------------------------------------------------------------
  always_comb begin
    code_ok   = (ram_data[7:4] == 4'd0) &&
                (ram_data[3:0] >= 4'd3) && (ram_data[3:0] <= 4'd12);
    dec_digit = code_ok ? (ram_data[3:0] - 4'd3) : 4'hF;
    mism      = !code_ok || (dec_digit != rd_exp1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1     <= 1'b0;
      rd_exp1   <= 4'd0;
      bcd_out   <= 4'd0;
      bcd_valid <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 5'd0;
    end else begin
      rd_v1     <= CS && !WE;
      // Expected digit for the address being read: addr mod 10 (addr < 16).
      rd_exp1   <= (addr >= 4'd10) ? (addr - 4'd10) : addr;
      bcd_valid <= rd_v1;
      err       <= rd_v1 && mism;
      if (rd_v1) begin
        bcd_out <= dec_digit;
      end
      // clr_cnt only fires in IDLE, where no read is in flight.
      if (clr_cnt) begin
        err_cnt <= 5'd0;
      end else if (rd_v1 && mism && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + 5'd1;
      end
    end
  end

endmodule
